// File: rtl/pulse_motion_ctrl.sv
// pulse_motion_ctrl: projectile controller for the pulse (fireball) attack.
// A fire request runs a wind-up, then the projectile launches from the owner's
// position. It moves once per video frame until it hits the opponent or leaves
// the screen. A hit is followed by an impact phase. Positions only change on a
// frame tick (falling edge of vs), so the sprite never tears mid-frame.
module pulse_motion_ctrl #(
  parameter int SPRITE_W      = 113,
  parameter int SCREEN_W      = 640,
  parameter int SPEED         = 8,
  parameter int SPAWN_DX      = 90,
  parameter int SPAWN_DY      = 0,
  parameter int OPP_W         = 60,
  parameter int WINDUP_FRAMES = 8,
  parameter int IMPACT_FRAMES = 6
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       vs,
  input  logic       fire,
  input  logic       facing,
  input  logic [9:0] OwnerX,
  input  logic [9:0] OwnerY,
  input  logic [9:0] OppX,
  output logic [9:0] PulseX,
  output logic [9:0] PulseY,
  output logic       pulse_active,
  output logic       pulse_hit,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WINDUP = 2'd1,
    ST_FLIGHT = 2'd2,
    ST_IMPACT = 2'd3
  } state_t;

  // Collision and screen-exit compares run at 11 bits so sums never wrap.
  localparam logic [10:0] SPRITE_W_W = 11'(SPRITE_W);
  localparam logic [10:0] SCREEN_W_W = 11'(SCREEN_W);
  localparam logic [10:0] SPEED_W    = 11'(SPEED);
  localparam logic [10:0] OPP_W_W    = 11'(OPP_W);
  localparam logic [9:0]  SPAWN_DX_W = 10'(SPAWN_DX);
  localparam logic [9:0]  SPAWN_DY_W = 10'(SPAWN_DY);
  localparam logic [5:0]  WINDUP_CNT = 6'(WINDUP_FRAMES);
  localparam logic [5:0]  IMPACT_CNT = 6'(IMPACT_FRAMES);

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        dir_q, dir_d;
  logic [9:0]  pulse_x_q, pulse_x_d;
  logic [9:0]  pulse_y_q, pulse_y_d;
  logic        active_q, active_d;
  logic        hit_q, hit_d;
  logic        busy_q, busy_d;
  logic        vs_q, vs_d;
  logic        fire_q, fire_d;

  logic        tick;
  logic        fire_edge;
  logic [5:0]  cnt_inc;
  logic [10:0] nx;
  logic [10:0] opp_x_w;
  logic        hit_now;
  logic        exit_now;
  logic [9:0]  spawn_x;

  // Edge detection, flight geometry and next-state selection.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    pulse_x_d = pulse_x_q;
    pulse_y_d = pulse_y_q;
    hit_d     = 1'b0;
    vs_d      = vs;
    fire_d    = fire;

    tick      = vs_q & ~vs;
    fire_edge = fire & ~fire_q;
    cnt_inc   = cnt_q + 6'd1;

    // Leftward spawn saturates at the screen's left edge.
    if (dir_q) begin
      spawn_x = (OwnerX < SPAWN_DX_W) ? 10'd0 : (OwnerX - SPAWN_DX_W);
    end else begin
      spawn_x = OwnerX + SPAWN_DX_W;
    end

    nx       = dir_q ? ({1'b0, pulse_x_q} - SPEED_W) : ({1'b0, pulse_x_q} + SPEED_W);
    opp_x_w  = {1'b0, OppX};
    // A leftward underflow wraps nx high, which can never satisfy the hit
    // compare; the exit test below catches that case instead.
    hit_now  = (nx < (opp_x_w + OPP_W_W)) && ((nx + SPRITE_W_W) > opp_x_w);
    exit_now = dir_q ? ({1'b0, pulse_x_q} < SPEED_W) : ((nx + SPRITE_W_W) > SCREEN_W_W);

    case (state_q)
      ST_IDLE: begin
        // A tick coinciding with the fire edge is deliberately not counted.
        if (fire_edge) begin
          dir_d   = facing;
          cnt_d   = 6'd0;
          state_d = ST_WINDUP;
        end
      end
      ST_WINDUP: begin
        if (tick) begin
          cnt_d = cnt_inc;
          if (cnt_inc == WINDUP_CNT) begin
            state_d   = ST_FLIGHT;
            pulse_x_d = spawn_x;
            pulse_y_d = OwnerY + SPAWN_DY_W;
          end
        end
      end
      ST_FLIGHT: begin
        if (tick) begin
          if (hit_now) begin
            pulse_x_d = nx[9:0];
            hit_d     = 1'b1;
            cnt_d     = 6'd0;
            state_d   = ST_IMPACT;
          end else if (exit_now) begin
            state_d = ST_IDLE;
          end else begin
            pulse_x_d = nx[9:0];
          end
        end
      end
      ST_IMPACT: begin
        if (tick) begin
          cnt_d = cnt_inc;
          if (cnt_inc == IMPACT_CNT) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    active_d = (state_d == ST_FLIGHT) || (state_d == ST_IMPACT);
    busy_d   = (state_d != ST_IDLE);
  end

  // State, position and registered outputs; fire_q resets high so a fire held
  // through reset release is not seen as an edge.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 6'd0;
      dir_q     <= 1'b0;
      pulse_x_q <= 10'd0;
      pulse_y_q <= 10'd0;
      active_q  <= 1'b0;
      hit_q     <= 1'b0;
      busy_q    <= 1'b0;
      vs_q      <= 1'b1;
      fire_q    <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      pulse_x_q <= pulse_x_d;
      pulse_y_q <= pulse_y_d;
      active_q  <= active_d;
      hit_q     <= hit_d;
      busy_q    <= busy_d;
      vs_q      <= vs_d;
      fire_q    <= fire_d;
    end
  end

  assign PulseX       = pulse_x_q;
  assign PulseY       = pulse_y_q;
  assign pulse_active = active_q;
  assign pulse_hit    = hit_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_pulse_motion_ctrl.sv
// Directed bench for pulse_motion_ctrl. Inputs change on the falling clock
// edge and outputs are observed on the falling edge, away from the active edge.
module tb_pulse_motion_ctrl;

  logic       vga_clk = 1'b0;
  logic       reset_n;
  logic       vs;
  logic       fire;
  logic       facing;
  logic [9:0] OwnerX;
  logic [9:0] OwnerY;
  logic [9:0] OppX;
  logic [9:0] PulseX;
  logic [9:0] PulseY;
  logic       pulse_active;
  logic       pulse_hit;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  pulse_motion_ctrl dut (
    .vga_clk      (vga_clk),
    .reset_n      (reset_n),
    .vs           (vs),
    .fire         (fire),
    .facing       (facing),
    .OwnerX       (OwnerX),
    .OwnerY       (OwnerY),
    .OppX         (OppX),
    .PulseX       (PulseX),
    .PulseY       (PulseY),
    .pulse_active (pulse_active),
    .pulse_hit    (pulse_hit),
    .busy         (busy)
  );

  always #5 vga_clk = ~vga_clk;

  // Packed view of all outputs: {PulseX, PulseY, pulse_active, pulse_hit, busy}.
  function automatic logic [22:0] obs();
    return {PulseX, PulseY, pulse_active, pulse_hit, busy};
  endfunction

  // One vs falling edge; returns on the falling clock edge right after the
  // tick was sampled, so its effects are already visible.
  task automatic frame_tick();
    @(negedge vga_clk); vs = 1'b0;
    @(negedge vga_clk); vs = 1'b1;
  endtask

  task automatic frame_ticks(input int n);
    for (int i = 0; i < n; i++) frame_tick();
  endtask

  // One-cycle fire pulse; returns one cycle after it was sampled.
  task automatic fire_pulse();
    @(negedge vga_clk); fire = 1'b1;
    @(negedge vga_clk); fire = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge vga_clk); reset_n = 1'b0;
    repeat (2) @(negedge vga_clk);
    reset_n = 1'b1;
    @(negedge vga_clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; vs = 1'b1; fire = 1'b1; facing = 1'b0;
    OwnerX = 10'd100; OwnerY = 10'd200; OppX = 10'd1000;
    repeat (3) @(negedge vga_clk);
    checks++;
    if (obs() !== 23'd0) begin
      failures++; $display("FAIL reset_values got=%h exp=%h", obs(), 23'd0);
    end
    // Release with fire still held: no edge, so nothing must launch.
    reset_n = 1'b1;
    repeat (3) @(negedge vga_clk);
    frame_ticks(2);
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL fire_held_through_reset busy got=%b exp=0", busy);
    end
    fire = 1'b0;
    @(negedge vga_clk);
  endtask

  task automatic test_right_launch_exit();
    do_reset();
    OwnerX = 10'd100; OwnerY = 10'd200; facing = 1'b0; OppX = 10'd1000;
    fire_pulse();
    checks++;
    if ({pulse_active, busy} !== 2'b01) begin
      failures++; $display("FAIL right_fire_busy got=%b exp=01", {pulse_active, busy});
    end
    frame_ticks(7);
    checks++;
    if ({pulse_active, busy} !== 2'b01) begin
      failures++; $display("FAIL right_windup_7 got=%b exp=01", {pulse_active, busy});
    end
    frame_tick();
    checks++;
    if (obs() !== {10'd190, 10'd200, 1'b1, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL right_launch got=%h exp=%h", obs(), {10'd190, 10'd200, 1'b1, 1'b0, 1'b1});
    end
    // Owner moves after launch and fire is pressed again: both must be ignored.
    OwnerX = 10'd300; OwnerY = 10'd50;
    fire_pulse();
    repeat (2) @(negedge vga_clk);
    checks++;
    if (obs() !== {10'd190, 10'd200, 1'b1, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL flight_fire_ignored got=%h exp=%h", obs(), {10'd190, 10'd200, 1'b1, 1'b0, 1'b1});
    end
    for (int i = 1; i <= 42; i++) begin
      frame_tick();
      checks++;
      if ({PulseX, pulse_active, pulse_hit} !== {10'(190 + 8 * i), 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL right_step_%0d x=%0d act=%b hit=%b exp_x=%0d", i, PulseX,
                 pulse_active, pulse_hit, 190 + 8 * i);
      end
    end
    frame_tick();
    checks++;
    if (obs() !== {10'd526, 10'd200, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL right_exit got=%h exp=%h", obs(), {10'd526, 10'd200, 1'b0, 1'b0, 1'b0});
    end
    // Idle holds the last position across further frames.
    frame_ticks(2);
    checks++;
    if (obs() !== {10'd526, 10'd200, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL idle_hold got=%h exp=%h", obs(), {10'd526, 10'd200, 1'b0, 1'b0, 1'b0});
    end
  endtask

  task automatic test_hit();
    OwnerX = 10'd100; OwnerY = 10'd200; facing = 1'b0; OppX = 10'd400;
    // Fire edge and tick in the same cycle: the tick must not count.
    @(negedge vga_clk); fire = 1'b1; vs = 1'b0;
    @(negedge vga_clk); fire = 1'b0; vs = 1'b1;
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL hit_fire_busy got=%b exp=1", busy);
    end
    frame_ticks(3);
    // Fire during wind-up with the other facing: must not restart or flip.
    facing = 1'b1;
    fire_pulse();
    facing = 1'b0;
    frame_ticks(4);
    checks++;
    if ({pulse_active, busy} !== 2'b01) begin
      failures++; $display("FAIL hit_windup_7 got=%b exp=01", {pulse_active, busy});
    end
    frame_tick();
    checks++;
    if (obs() !== {10'd190, 10'd200, 1'b1, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL hit_launch got=%h exp=%h", obs(), {10'd190, 10'd200, 1'b1, 1'b0, 1'b1});
    end
    frame_ticks(12);
    checks++;
    if (obs() !== {10'd286, 10'd200, 1'b1, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL hit_pre_contact got=%h exp=%h", obs(), {10'd286, 10'd200, 1'b1, 1'b0, 1'b1});
    end
    frame_tick();
    checks++;
    if (obs() !== {10'd294, 10'd200, 1'b1, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL hit_contact got=%h exp=%h", obs(), {10'd294, 10'd200, 1'b1, 1'b1, 1'b1});
    end
    @(negedge vga_clk);
    checks++;
    if (pulse_hit !== 1'b0) begin
      failures++; $display("FAIL hit_one_cycle got=%b exp=0", pulse_hit);
    end
    frame_ticks(5);
    checks++;
    if (obs() !== {10'd294, 10'd200, 1'b1, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL impact_5 got=%h exp=%h", obs(), {10'd294, 10'd200, 1'b1, 1'b0, 1'b1});
    end
    frame_tick();
    checks++;
    if (obs() !== {10'd294, 10'd200, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL impact_end got=%h exp=%h", obs(), {10'd294, 10'd200, 1'b0, 1'b0, 1'b0});
    end
  endtask

  task automatic test_left_saturation();
    OwnerX = 10'd50; OwnerY = 10'd300; facing = 1'b1; OppX = 10'd1000;
    fire_pulse();
    facing = 1'b0;
    frame_ticks(8);
    checks++;
    if (obs() !== {10'd0, 10'd300, 1'b1, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL left_spawn got=%h exp=%h", obs(), {10'd0, 10'd300, 1'b1, 1'b0, 1'b1});
    end
    frame_tick();
    checks++;
    if (obs() !== {10'd0, 10'd300, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL left_exit got=%h exp=%h", obs(), {10'd0, 10'd300, 1'b0, 1'b0, 1'b0});
    end
  endtask

  task automatic test_async_reset();
    OwnerX = 10'd100; OwnerY = 10'd200; facing = 1'b0; OppX = 10'd1000;
    fire_pulse();
    frame_ticks(10);
    checks++;
    if (obs() !== {10'd206, 10'd200, 1'b1, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL pre_reset_flight got=%h exp=%h", obs(), {10'd206, 10'd200, 1'b1, 1'b0, 1'b1});
    end
    @(posedge vga_clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (obs() !== 23'd0) begin
      failures++; $display("FAIL async_reset got=%h exp=%h", obs(), 23'd0);
    end
    @(negedge vga_clk); reset_n = 1'b1;
    @(negedge vga_clk);
    fire_pulse();
    checks++;
    if ({pulse_active, busy} !== 2'b01) begin
      failures++; $display("FAIL restart_after_reset got=%b exp=01", {pulse_active, busy});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_right_launch_exit();
    test_hit();
    test_left_saturation();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
